// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the MIPS pipeline MEM stage. Stores complete in
//   a single cycle. Loads take READ_LAT cycles, and `stall` holds the pipeline
//   for that time. `err` is a sticky flag for misaligned or conflicting
//   requests.
//
// Parameters
//   DEPTH     number of 32-bit words (power of two, 16..4096)
//   READ_LAT  load latency in cycles (1..15)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   adr        in   [31:0] byte address (word index = adr[log2(DEPTH)+1:2])
//   wdata      in   [31:0] store data
//   mem_read   in   load request, level-sensitive
//   mem_write  in   store request, level-sensitive
//   rdata      out  [31:0] registered load data, held until the next load completes
//   stall      out  combinational pipeline hold request
//   err        out  sticky error flag, cleared only by reset
module dmem_responder #(
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned READ_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] adr,
   input  logic [31:0] wdata,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        err
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt_nxt;
   logic [AW-1:0] r_adr_q;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic [31:0]   r_mem [DEPTH];

   logic [AW-1:0] w_idx;
   logic [AW-1:0] w_rd_idx;
   logic          w_idle;
   logic          w_valid;
   logic          w_ld;
   logic          w_st;
   logic          w_bad;
   logic          w_rd_en;

   // Address bits above the word index are ignored, so addresses wrap.
   logic          w_unused_adr;
   assign w_unused_adr = &{1'b0, adr[31:AW+2]};

   assign w_idx   = adr[AW+1:2];
   assign w_idle  = (r_state == S_IDLE);
   assign w_valid = (adr[1:0] == 2'b00) && (mem_read ^ mem_write);
   assign w_ld    = w_idle && w_valid && mem_read;
   // Blocking the write while reset is held keeps the array untouched
   // during reset.
   assign w_st    = rst && w_idle && w_valid && mem_write;
   assign w_bad   = w_idle && (mem_read || mem_write) && !w_valid;

   // Gated by reset so that a held load strobe does not stall a pipeline
   // that is itself in reset.
   assign stall   = rst && (w_ld || (r_state == S_BUSY));
   assign rdata   = r_rdata;
   assign err     = r_err;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rd_en     = 1'b0;
      w_rd_idx    = r_adr_q;
      case (r_state)
         S_IDLE: begin
            if (w_ld) begin
               if (READ_LAT > 1) begin
                  w_state_nxt = S_BUSY;
                  w_cnt_nxt   = 4'(READ_LAT - 1);
               end else begin
                  // Single-cycle latency reads straight from the live index.
                  w_state_nxt = S_DONE;
                  w_rd_en     = 1'b1;
                  w_rd_idx    = w_idx;
               end
            end
         end
         S_BUSY: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_rd_en     = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_adr_q <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_ld) begin
            r_adr_q <= w_idx;
         end
         if (w_rd_en) begin
            r_rdata <= r_mem[w_rd_idx];
         end
         if (w_bad) begin
            r_err <= 1'b1;
         end
      end
   end

   // Storage array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_st) begin
         r_mem[w_idx] <= wdata;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. Two instances share one stimulus stream:
// instance 0 uses READ_LAT=2, instance 1 uses READ_LAT=1. A cycle-level model
// tracks when each load was issued, and the compare process checks stall,
// err and rdata of both instances on every falling edge.
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic [31:0] adr;
   logic [31:0] wdata;
   logic        mem_read;
   logic        mem_write;
   logic [1:0][31:0] rdata_a;
   logic [1:0]       stall_a;
   logic [1:0]       err_a;

   int checks   = 0;
   int failures = 0;

   dmem_responder #(.DEPTH(256), .READ_LAT(2)) u_dut_lat2 (
      .clk(clk), .rst(rst), .adr(adr), .wdata(wdata),
      .mem_read(mem_read), .mem_write(mem_write),
      .rdata(rdata_a[0]), .stall(stall_a[0]), .err(err_a[0])
   );

   dmem_responder #(.DEPTH(256), .READ_LAT(1)) u_dut_lat1 (
      .clk(clk), .rst(rst), .adr(adr), .wdata(wdata),
      .mem_read(mem_read), .mem_write(mem_write),
      .rdata(rdata_a[1]), .stall(stall_a[1]), .err(err_a[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A load issued in cycle t occupies cycles t+1..t+LAT (busy, then done);
   // data becomes visible in cycle t+LAT.
   int          cyc = 0;
   int          m_issue [2];
   logic [7:0]  m_ladr  [2];
   logic [31:0] m_rdata [2];
   bit          m_rknown[2];
   bit          m_err   [2];
   logic [31:0] m_mem   [2][256];
   bit          m_known [2][256];

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_issue[k]  = -1000;
         m_rdata[k]  = '0;
         m_rknown[k] = 1'b1;
         m_err[k]    = 1'b0;
         for (int i = 0; i < 256; i++) m_known[k][i] = 1'b0;
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit   in_idle;
         bit   valid;
         bit   exp_stall;
         logic [7:0] idx;
         int   lat;
         lat   = lat_of(k);
         idx   = adr[9:2];
         valid = (adr[1:0] == 2'b00) && (mem_read ^ mem_write);
         in_idle = !(cyc > m_issue[k] && cyc <= m_issue[k] + lat);
         if (!rst) begin
            m_issue[k]  = -1000;
            m_rdata[k]  = '0;
            m_rknown[k] = 1'b1;
            m_err[k]    = 1'b0;
            exp_stall   = 1'b0;
         end else if (in_idle) begin
            exp_stall = valid && mem_read;
         end else begin
            exp_stall = (cyc < m_issue[k] + lat);
         end

         chk($sformatf("model_stall[%0d]", k), {31'd0, stall_a[k]}, {31'd0, exp_stall});
         chk($sformatf("model_err[%0d]", k), {31'd0, err_a[k]}, {31'd0, m_err[k]});
         if (m_rknown[k]) chk($sformatf("model_rdata[%0d]", k), rdata_a[k], m_rdata[k]);

         if (rst) begin
            if (in_idle) begin
               if (valid && mem_write) begin
                  m_mem[k][idx]   = wdata;
                  m_known[k][idx] = 1'b1;
               end
               if (valid && mem_read) begin
                  m_issue[k] = cyc;
                  m_ladr[k]  = idx;
               end
               if ((mem_read || mem_write) && !valid) m_err[k] = 1'b1;
            end
            if (cyc == m_issue[k] + lat - 1) begin
               m_rdata[k]  = m_mem[k][m_ladr[k]];
               m_rknown[k] = m_known[k][m_ladr[k]];
            end
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      mem_read  = rd;
      mem_write = wr;
      adr       = a;
      wdata     = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic load_and_wait(input logic [31:0] a);
      drive(1'b1, 1'b0, a, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) tick();
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b1, 1'b0, 32'h10, 32'h0);
      tick();
      // Reset held with a load strobe asserted.
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("rst_stall0", {31'd0, stall_a[0]}, 32'd0);
         chk("rst_stall1", {31'd0, stall_a[1]}, 32'd0);
         chk("rst_rdata0", rdata_a[0], 32'h0);
         chk("rst_err0", {31'd0, err_a[0]}, 32'd0);
         tick();
      end

      rst = 1'b1;
      drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);  tick();
      drive(1'b0, 1'b1, 32'h14, 32'h12345678);  tick();
      drive(1'b0, 1'b1, 32'h20, 32'h0BADF00D);  tick();
      // 0x400 wraps onto word 0.
      drive(1'b0, 1'b1, 32'h400, 32'hCAFEF00D); tick();

      // Load @0x10 in cycle L.
      drive(1'b1, 1'b0, 32'h10, 32'h0);
      #2;
      chk("ld_issue_stall0", {31'd0, stall_a[0]}, 32'd1);
      chk("ld_issue_stall1", {31'd1 & 31'd0, stall_a[1]}, 32'd1);
      tick();
      // L+1: store attempt while busy must be dropped.
      drive(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF);
      #2;
      chk("busy_stall0", {31'd0, stall_a[0]}, 32'd1);
      chk("done_stall1", {31'd0, stall_a[1]}, 32'd0);
      chk("done_rdata1", rdata_a[1], 32'hDEADBEEF);
      tick();
      // L+2: lat2 in DONE ignores the held load; lat1 accepts it.
      drive(1'b1, 1'b0, 32'h14, 32'h0);
      #2;
      chk("done_stall0", {31'd0, stall_a[0]}, 32'd0);
      chk("done_rdata0", rdata_a[0], 32'hDEADBEEF);
      chk("b2b_issue_stall1", {31'd0, stall_a[1]}, 32'd1);
      tick();
      // L+3: lat2 accepts the second load.
      #2;
      chk("b2b_issue_stall0", {31'd0, stall_a[0]}, 32'd1);
      chk("b2b_rdata1", rdata_a[1], 32'h12345678);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      chk("b2b_busy_stall0", {31'd0, stall_a[0]}, 32'd1);
      tick();
      #2;
      chk("b2b_done_rdata0", rdata_a[0], 32'h12345678);
      chk("b2b_done_stall0", {31'd0, stall_a[0]}, 32'd0);
      tick();

      // Word 0x20 must not have taken the dropped store.
      load_and_wait(32'h20);
      chk("dropped_store0", rdata_a[0], 32'h0BADF00D);
      chk("dropped_store1", rdata_a[1], 32'h0BADF00D);

      // Misaligned store.
      drive(1'b0, 1'b1, 32'h13, 32'hAAAA5555);
      #2;
      chk("misal_stall0", {31'd0, stall_a[0]}, 32'd0);
      tick();
      #2;
      chk("misal_err0", {31'd0, err_a[0]}, 32'd1);
      chk("misal_err1", {31'd0, err_a[1]}, 32'd1);
      // Conflicting strobes.
      drive(1'b1, 1'b1, 32'h10, 32'h11111111);
      #2;
      chk("conflict_stall0", {31'd0, stall_a[0]}, 32'd0);
      tick();
      // Misaligned load never stalls.
      drive(1'b1, 1'b0, 32'h12, 32'h0);
      #2;
      chk("misal_ld_stall0", {31'd0, stall_a[0]}, 32'd0);
      chk("misal_ld_stall1", {31'd0, stall_a[1]}, 32'd0);
      tick();
      load_and_wait(32'h10);
      chk("no_write_after_err0", rdata_a[0], 32'hDEADBEEF);
      chk("no_write_after_err1", rdata_a[1], 32'hDEADBEEF);
      chk("err_sticky0", {31'd0, err_a[0]}, 32'd1);

      // Wrap-around.
      load_and_wait(32'h0);
      chk("wrap0", rdata_a[0], 32'hCAFEF00D);
      chk("wrap1", rdata_a[1], 32'hCAFEF00D);

      // Reset while lat2 is busy.
      drive(1'b1, 1'b0, 32'h14, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      #1;
      chk("midrst_stall0", {31'd0, stall_a[0]}, 32'd0);
      chk("midrst_rdata0", rdata_a[0], 32'h0);
      chk("midrst_rdata1", rdata_a[1], 32'h0);
      chk("midrst_err0", {31'd0, err_a[0]}, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      load_and_wait(32'h14);
      chk("after_rst0", rdata_a[0], 32'h12345678);
      chk("after_rst1", rdata_a[1], 32'h12345678);

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS pipeline. It sits on the far side of the datapath's data-memory port: it takes the address, write data and read/write strobes from the MEM stage and returns read data. Stores complete in one cycle. Loads take a fixed multi-cycle latency, and during that time the block raises `stall` so the hazard logic freezes the pipeline. It also flags misaligned or conflicting requests through a sticky error bit.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, 16..4096.
- `READ_LAT`, 2: load latency in cycles, 1..15.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `adr`  in  32  byte address from the datapath (`data_adr`).
- `wdata`  in  32  store data from the datapath (`data_out`).
- `mem_read`  in  1  load request, level-sensitive.
- `mem_write`  in  1  store request, level-sensitive.
- `rdata`  out  32  load data to the datapath (`data_in`), registered.
- `stall`  out  1  pipeline hold request.
- `err`  out  1  sticky error flag, registered.

## Operation
- **Indexing**
  - Word index = `adr[log2(DEPTH)+1:2]`.
  - Upper address bits are ignored, so addresses wrap modulo `DEPTH*4`.
- **Storage**: `DEPTH` x 32 array, not reset; contents are undefined until written.
- **Request validity**: a request is valid only when `adr[1:0]==0` and exactly one of `mem_read`/`mem_write` is high.
  - Misaligned request: no array access, `err` set.
  - Both strobes high: no array access, `err` set.
  - A misaligned or conflicting request never starts a load and never raises `stall`.
- **FSM states**: IDLE, BUSY, DONE. 4-bit down-counter `cnt`.
- **IDLE**
  - Valid store: array word written at the clock edge. Stay in IDLE.
  - Valid load: latch the word index into `adr_q`. If `READ_LAT>1`, go to BUSY with `cnt=READ_LAT-1`; otherwise go to DONE.
- **BUSY**
  - `cnt` decrements every cycle.
  - On the edge where `cnt==1`: `rdata` <= array[`adr_q`], go to DONE.
- **READ_LAT=1**: the IDLE->DONE edge loads `rdata` <= array[index].
- **DONE**
  - Always returns to IDLE on the next edge.
  - Inputs seen in DONE belong to the completing load and are ignored, so no new access can start in DONE.
- **BUSY/DONE input handling**: changes to `adr`, `wdata` and the strobes are ignored; stores are dropped.
- **`rdata`**: holds its value until the next load completes.
- **`err`**: set on any invalid request seen in IDLE; cleared only by reset.

## Timing
- **Reset values** (`rst` low, asynchronous): state=IDLE, `cnt`=0, `rdata`=0, `stall`=0, `err`=0, `adr_q`=0.
- **Reset mid-load**: the load is discarded. The array keeps its contents, except that a write coincident with reset assertion is not guaranteed.
- **`stall`** is combinational: `(state==IDLE && valid load) || state==BUSY`.
- **Load issued in cycle 0**:
  - `stall` is high in cycles 0..`READ_LAT`-1.
  - `rdata` is valid and `stall` low in cycle `READ_LAT`, which is the DONE cycle. The pipeline advances at the end of that cycle.
- **Back-to-back loads**: the second load is accepted in cycle `READ_LAT`+1. Throughput is one load per `READ_LAT`+1 cycles.
- **Stores**: zero stall; the write is visible to a load issued in the next cycle.
- **Same-cycle store then load to the same word**: impossible, because a store and a load in one request is an error.

## Test plan
- **Reset**: hold `rst`=0 for 3 cycles with `mem_read`=1 -> `stall`=0, `rdata`=0, `err`=0 throughout.
- **Store then load**, `READ_LAT`=2:
  - Store `0xDEADBEEF` @`0x10`, then load @`0x10`.
  - `stall`=1 for exactly 2 cycles; `rdata`=`0xDEADBEEF` with `stall`=0 in the 3rd cycle.
  - Next load @`0x14` (written `0x12345678`) is accepted one cycle later.
- **Address change mid-load**: during BUSY, change `adr` to `0x20` and pulse `mem_write` with `wdata`=`0xFFFFFFFF`.
  - `rdata` still returns word `0x10`.
  - Word `0x20` is unchanged (verify by a later load).
- **Errors**:
  - Store `0xAAAA5555` @`0x13` -> `err`=1, `stall`=0; word `0x10` still reads `0xDEADBEEF`.
  - `mem_read` & `mem_write` @`0x10` -> no write.
  - `err` stays 1 until reset.
- **Wrap-around**, `DEPTH`=256: store `0xCAFEF00D` @`0x400`; load @`0x0` -> `0xCAFEF00D`.
- **Reset mid-load and READ_LAT=1**:
  - Assert `rst` during BUSY -> immediately state IDLE, `stall`=0, `rdata`=0.
  - With `READ_LAT`=1: `stall` is high only in the issue cycle and data arrives in the next cycle.
